elf_dma_loader: RTL

ELF_DMA_LOADER -- requirements
Module: elf_dma_loader

---
 rtl/elf_pkg.sv | 17 +
 rtl/elf_dma_loader_if.sv | 27 ++
 rtl/elf_debounce.sv | 49 ++++
 rtl/elf_dma_loader.sv | 101 ++++++++++
 4 files changed

// File: rtl/elf_pkg.sv
// Shared definitions for the ELF front-panel DMA loader.
// Holds the CPU state-code constants and the loader FSM state type.
package elf_pkg;

  localparam logic [1:0] SC_FETCH   = 2'b00;
  localparam logic [1:0] SC_EXECUTE = 2'b01;
  localparam logic [1:0] SC_DMA     = 2'b10;
  localparam logic [1:0] SC_INT     = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_REQ,
    ST_XFER,
    ST_RELEASE
  } state_t;

endpackage

// File: rtl/elf_dma_loader_if.sv
// CPU-side DMA bus between the loader (master) and the CPU (slave).
interface elf_dma_loader_if;
  import elf_pkg::*;

  logic [1:0] sc;
  logic       mem_write;
  logic       dma_in_req;
  logic [7:0] data_out;
  logic       data_oe;

  modport master (
    input  sc,
    input  mem_write,
    output dma_in_req,
    output data_out,
    output data_oe
  );

  modport slave (
    output sc,
    output mem_write,
    input  dma_in_req,
    input  data_out,
    input  data_oe
  );

endinterface

// File: rtl/elf_debounce.sv
// Two-flop synchronizer plus tick-qualified debouncer for the IN button.
// rise is a single-tick pulse on the accepted 0->1 level change.
module elf_debounce #(
  parameter int unsigned DEBOUNCE_CYCLES = 16
) (
  input  logic clk,
  input  logic reset,
  input  logic clk_enable,
  input  logic in_btn,
  output logic level,
  output logic rise
);

  logic       sync1, sync2;
  logic [7:0] cnt;
  logic       accept;

  // Synchronizer runs every clock, independent of clk_enable.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
    end else begin
      sync1 <= in_btn;
      sync2 <= sync1;
    end
  end

  // Accept on the DEBOUNCE_CYCLES-th consecutive tick that disagrees with level.
  assign accept = clk_enable && (sync2 != level) && (cnt == 8'(DEBOUNCE_CYCLES - 1));
  assign rise   = accept && sync2;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt   <= '0;
      level <= 1'b0;
    end else if (clk_enable) begin
      if (sync2 == level) begin
        cnt <= '0;
      end else if (accept) begin
        cnt   <= '0;
        level <= sync2;
      end else begin
        cnt <= cnt + 8'd1;
      end
    end
  end

endmodule

// File: rtl/elf_dma_loader.sv
// Front-panel LOAD-mode DMA loader: one debounced IN press deposits the
// toggle-switch byte into memory through one CPU DMA-in cycle.
module elf_dma_loader
  import elf_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 16
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    clk_enable,
  input  logic                    load_mode,
  input  logic                    in_btn,
  input  logic [7:0]              sw_data,
  elf_dma_loader_if.master        bus,
  output logic [15:0]             addr_shadow,
  output logic                    busy,
  output logic                    overrun
);

  state_t      state, state_nx;
  logic        btn_level, trigger;
  logic        load_prev, load_rise;
  logic        load_data, inc_addr;
  logic [7:0]  data_q;
  logic [15:0] addr_q;

  elf_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_debounce (
    .clk        (clk),
    .reset      (reset),
    .clk_enable (clk_enable),
    .in_btn     (in_btn),
    .level      (btn_level),
    .rise       (trigger)
  );

  assign load_rise = clk_enable && load_mode && !load_prev;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx  = state;
    load_data = 1'b0;
    inc_addr  = 1'b0;
    if (clk_enable) begin
      if (!load_mode) begin
        state_nx = ST_IDLE;
      end else begin
        unique case (state)
          ST_IDLE: begin
            if (trigger) begin
              state_nx  = ST_REQ;
              load_data = 1'b1;
            end
          end
          ST_REQ: begin
            if (bus.sc == SC_DMA) state_nx = ST_XFER;
          end
          ST_XFER: begin
            if (bus.sc != SC_DMA) begin
              state_nx = ST_RELEASE;
            end else if (bus.mem_write) begin
              state_nx = ST_RELEASE;
              inc_addr = 1'b1;
            end
          end
          ST_RELEASE: begin
            if (!btn_level) state_nx = ST_IDLE;
          end
          default: state_nx = ST_IDLE;
        endcase
      end
    end
  end

  // load_prev only samples on ticks, so a load_rise always finds the FSM idle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      load_prev <= 1'b0;
      data_q    <= '0;
      addr_q    <= '0;
      overrun   <= 1'b0;
    end else begin
      if (clk_enable) load_prev <= load_mode;
      if (load_data)  data_q    <= sw_data;
      if (load_rise)     addr_q <= '0;
      else if (inc_addr) addr_q <= addr_q + 16'd1;
      if (load_rise)                          overrun <= 1'b0;
      else if (trigger && state != ST_IDLE)   overrun <= 1'b1;
    end
  end

  assign bus.dma_in_req = (state == ST_REQ) && load_mode;
  assign bus.data_oe    = (state == ST_XFER) && (bus.sc == SC_DMA) && load_mode;
  assign bus.data_out   = data_q;
  assign addr_shadow    = addr_q;
  assign busy           = (state != ST_IDLE);

endmodule
